// File: rtl/axi_mem_slave_if.sv
// axi_mem_slave_if: AXI4 write (AW/W/B) and read (AR/R) channel bundle
// between a burst master and the axi_mem_slave responder.
interface axi_mem_slave_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 4
);
  // write address channel
  logic [ID_WIDTH-1:0]     awid;
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [7:0]              awlen;
  logic [2:0]              awsize;
  logic [1:0]              awburst;
  logic                    awvalid;
  logic                    awready;
  // write data channel
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wlast;
  logic                    wvalid;
  logic                    wready;
  // write response channel
  logic [ID_WIDTH-1:0]     bid;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;
  // read address channel
  logic [ID_WIDTH-1:0]     arid;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic [7:0]              arlen;
  logic [2:0]              arsize;
  logic [1:0]              arburst;
  logic                    arvalid;
  logic                    arready;
  // read data channel
  logic [ID_WIDTH-1:0]     rid;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rlast;
  logic                    rvalid;
  logic                    rready;

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready,
    input  arid, araddr, arlen, arsize, arburst, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready
  );

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready,
    output arid, araddr, arlen, arsize, arburst, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready
  );
endinterface

// File: rtl/axi_mem_slave.sv
// axi_mem_slave: AXI4 INCR-burst responder over a word-addressed RAM.
// Independent write and read sequencers, one burst in flight per channel,
// read-first on same-word collisions, RAM contents survive reset.
// Optional feature macro: AXI_MEM_WSTRB_EN (per-byte write strobes honoured);
// when undefined every accepted beat writes the full word.
module axi_mem_slave #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 4,
  parameter int MEM_DEPTH  = 256
) (
  input  logic           clk,
  input  logic           rst,
  axi_mem_slave_if.slave bus
);

  localparam int               STRB_W      = DATA_WIDTH / 8;
  localparam int               BYTE_SH     = $clog2(STRB_W);
  localparam int               IDX_W       = $clog2(MEM_DEPTH);
  localparam logic [2:0]       SIZE_ENC    = 3'(BYTE_SH);
  localparam logic [1:0]       BURST_INCR  = 2'b01;
  localparam logic [1:0]       RESP_OKAY   = 2'b00;
  localparam logic [1:0]       RESP_SLVERR = 2'b10;
  localparam logic [IDX_W-1:0] IDX_ONE     = IDX_W'(1);

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_DATA = 2'd1,
    W_RESP = 2'd2
  } w_state_t;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } r_state_t;

  // Only full-width INCR bursts address the RAM; anything else is answered
  // with SLVERR while still completing every handshake.
  function automatic logic burst_bad(input logic [1:0] burst, input logic [2:0] size);
    return (burst != BURST_INCR) || (size != SIZE_ENC);
  endfunction

  logic [DATA_WIDTH-1:0] mem_r [MEM_DEPTH];

  // write channel state
  w_state_t          w_state_r;
  logic              awready_r;
  logic              wready_r;
  logic              bvalid_r;
  logic [ID_WIDTH-1:0] bid_r;
  logic [1:0]        bresp_r;
  logic [ID_WIDTH-1:0] w_id_r;
  logic [IDX_W-1:0]  w_idx_r;
  logic [7:0]        w_len_r;
  logic [7:0]        w_cnt_r;
  logic              w_err_r;
  logic              w_last_bad_r;

  // read channel state
  r_state_t          r_state_r;
  logic              arready_r;
  logic              rvalid_r;
  logic              rlast_r;
  logic [ID_WIDTH-1:0] rid_r;
  logic [1:0]        rresp_r;
  logic [DATA_WIDTH-1:0] rdata_r;
  logic [IDX_W-1:0]  r_idx_r;
  logic [7:0]        r_len_r;
  logic [7:0]        r_cnt_r;
  logic              r_err_r;

  logic              w_fire_s;
  logic              w_final_s;
  logic              w_last_mis_s;
  logic              r_fire_s;
  logic [IDX_W-1:0]  aw_idx_s;
  logic [IDX_W-1:0]  ar_idx_s;
  logic              ar_err_s;
  logic              unused_s;

  assign w_fire_s     = wready_r & bus.wvalid;
  assign w_final_s    = (w_cnt_r == w_len_r);
  // wlast must be high on exactly the counted final beat
  assign w_last_mis_s = (bus.wlast != w_final_s);
  assign r_fire_s     = rvalid_r & bus.rready;
  assign aw_idx_s     = bus.awaddr[BYTE_SH +: IDX_W];
  assign ar_idx_s     = bus.araddr[BYTE_SH +: IDX_W];
  assign ar_err_s     = burst_bad(bus.arburst, bus.arsize);

  // byte-offset and out-of-range address bits are deliberately ignored
`ifdef AXI_MEM_WSTRB_EN
  assign unused_s = ^{bus.awaddr, bus.araddr};
`else
  assign unused_s = ^{bus.awaddr, bus.araddr, bus.wstrb};
`endif

  assign bus.awready = awready_r;
  assign bus.wready  = wready_r;
  assign bus.bvalid  = bvalid_r;
  assign bus.bid     = bid_r;
  assign bus.bresp   = bresp_r;
  assign bus.arready = arready_r;
  assign bus.rvalid  = rvalid_r;
  assign bus.rlast   = rlast_r;
  assign bus.rid     = rid_r;
  assign bus.rresp   = rresp_r;
  assign bus.rdata   = rdata_r;

  // Write sequencer: accept address, count beats, issue one B response
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      w_state_r    <= W_IDLE;
      awready_r    <= 1'b0;
      wready_r     <= 1'b0;
      bvalid_r     <= 1'b0;
      bid_r        <= {ID_WIDTH{1'b0}};
      bresp_r      <= RESP_OKAY;
      w_id_r       <= {ID_WIDTH{1'b0}};
      w_idx_r      <= {IDX_W{1'b0}};
      w_len_r      <= 8'd0;
      w_cnt_r      <= 8'd0;
      w_err_r      <= 1'b0;
      w_last_bad_r <= 1'b0;
    end else begin
      case (w_state_r)
        W_IDLE: begin
          if (awready_r && bus.awvalid) begin
            awready_r    <= 1'b0;
            wready_r     <= 1'b1;
            w_id_r       <= bus.awid;
            w_idx_r      <= aw_idx_s;
            w_len_r      <= bus.awlen;
            w_cnt_r      <= 8'd0;
            w_err_r      <= burst_bad(bus.awburst, bus.awsize);
            w_last_bad_r <= 1'b0;
            w_state_r    <= W_DATA;
          end else begin
            awready_r <= 1'b1;
          end
        end
        W_DATA: begin
          if (w_fire_s) begin
            w_idx_r <= w_idx_r + IDX_ONE;
            w_cnt_r <= w_cnt_r + 8'd1;
            if (w_final_s) begin
              wready_r  <= 1'b0;
              bvalid_r  <= 1'b1;
              bid_r     <= w_id_r;
              bresp_r   <= (w_err_r || w_last_bad_r || w_last_mis_s) ? RESP_SLVERR : RESP_OKAY;
              w_state_r <= W_RESP;
            end else begin
              w_last_bad_r <= w_last_bad_r | w_last_mis_s;
            end
          end
        end
        W_RESP: begin
          if (bus.bready) begin
            bvalid_r  <= 1'b0;
            awready_r <= 1'b1;
            w_state_r <= W_IDLE;
          end
        end
        default: begin
          awready_r <= 1'b0;
          wready_r  <= 1'b0;
          bvalid_r  <= 1'b0;
          w_state_r <= W_IDLE;
        end
      endcase
    end
  end

  // RAM write port; left unreset so contents persist across rst
  always_ff @(posedge clk) begin
    if (w_fire_s && !w_err_r) begin
`ifdef AXI_MEM_WSTRB_EN
      for (int b = 0; b < STRB_W; b++) begin
        if (bus.wstrb[b]) begin
          mem_r[w_idx_r][b*8 +: 8] <= bus.wdata[b*8 +: 8];
        end
      end
`else
      mem_r[w_idx_r] <= bus.wdata;
`endif
    end
  end

  // Read sequencer: fetch beat 0 on AR, then one beat per R handshake.
  // The RAM is read here before the same-edge write lands (read-first).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state_r <= R_IDLE;
      arready_r <= 1'b0;
      rvalid_r  <= 1'b0;
      rlast_r   <= 1'b0;
      rid_r     <= {ID_WIDTH{1'b0}};
      rresp_r   <= RESP_OKAY;
      rdata_r   <= {DATA_WIDTH{1'b0}};
      r_idx_r   <= {IDX_W{1'b0}};
      r_len_r   <= 8'd0;
      r_cnt_r   <= 8'd0;
      r_err_r   <= 1'b0;
    end else begin
      case (r_state_r)
        R_IDLE: begin
          if (arready_r && bus.arvalid) begin
            arready_r <= 1'b0;
            rvalid_r  <= 1'b1;
            rid_r     <= bus.arid;
            r_idx_r   <= ar_idx_s + IDX_ONE;
            r_len_r   <= bus.arlen;
            r_cnt_r   <= 8'd0;
            r_err_r   <= ar_err_s;
            rresp_r   <= ar_err_s ? RESP_SLVERR : RESP_OKAY;
            rdata_r   <= ar_err_s ? {DATA_WIDTH{1'b0}} : mem_r[ar_idx_s];
            rlast_r   <= (bus.arlen == 8'd0);
            r_state_r <= R_DATA;
          end else begin
            arready_r <= 1'b1;
          end
        end
        R_DATA: begin
          if (r_fire_s) begin
            if (rlast_r) begin
              rvalid_r  <= 1'b0;
              rlast_r   <= 1'b0;
              arready_r <= 1'b1;
              r_state_r <= R_IDLE;
            end else begin
              rdata_r <= r_err_r ? {DATA_WIDTH{1'b0}} : mem_r[r_idx_r];
              r_idx_r <= r_idx_r + IDX_ONE;
              r_cnt_r <= r_cnt_r + 8'd1;
              rlast_r <= ((r_cnt_r + 8'd1) == r_len_r);
            end
          end
        end
        default: begin
          arready_r <= 1'b0;
          rvalid_r  <= 1'b0;
          rlast_r   <= 1'b0;
          r_state_r <= R_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axi_mem_slave.sv
// tb_axi_mem_slave: directed bursts against a word-array memory model with
// expected-beat / expected-response queues, plus literal spot checks.
module tb_axi_mem_slave;
  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int IW    = 4;
  localparam int DEPTH = 256;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  axi_mem_slave_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW)) bus ();

  axi_mem_slave #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW), .MEM_DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int vectors     = 0;
  int miscompares = 0;

  logic [31:0] model_mem [DEPTH];
  logic [38:0] exp_r [$];   // {rid, rdata, rresp, rlast}
  logic [5:0]  exp_b [$];   // {bid, bresp}
  logic [31:0] wbuf [256];
  logic [31:0] got  [256];
  int          ngot;
  logic [1:0]  last_bresp;
  logic [31:0] exp4 [4] = '{32'hFACECAFE, 32'hDEADBEEF, 32'h12345678, 32'h87654321};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic note_fail(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s: bound expired or unexpected activity", name);
  endtask

  // Model: INCR full-width bursts write consecutive words modulo DEPTH.
  task automatic model_write(input logic [3:0] id, input logic [31:0] addr, input int len,
                             input logic [1:0] burst, input logic [2:0] size,
                             input logic [3:0] strb, input int wlast_at);
    bit err;
    int base;
    int idx;
    err  = (burst != 2'b01) || (size != 3'd2);
    base = int'((addr / 32'd4) % DEPTH);
    if (!err) begin
      for (int i = 0; i <= len; i++) begin
        idx = (base + i) % DEPTH;
`ifdef AXI_MEM_WSTRB_EN
        for (int b = 0; b < 4; b++) begin
          if (strb[b]) model_mem[idx][8*b +: 8] = wbuf[i][8*b +: 8];
        end
`else
        model_mem[idx] = wbuf[i];
`endif
      end
    end
    exp_b.push_back({id, (err || (wlast_at != len)) ? 2'b10 : 2'b00});
  endtask

  task automatic model_read(input logic [3:0] id, input logic [31:0] addr, input int len,
                            input logic [1:0] burst, input logic [2:0] size);
    bit err;
    int base;
    logic [31:0] d;
    err  = (burst != 2'b01) || (size != 3'd2);
    base = int'((addr / 32'd4) % DEPTH);
    for (int i = 0; i <= len; i++) begin
      d = err ? 32'h0 : model_mem[(base + i) % DEPTH];
      exp_r.push_back({id, d, err ? 2'b10 : 2'b00, (i == len) ? 1'b1 : 1'b0});
    end
  endtask

  // Compare process: every presented R beat and B response against the model
  always @(negedge clk) begin
    if (rst) begin
      if (bus.rvalid) begin
        if (exp_r.size() == 0) begin
          note_fail("r_unexpected_beat");
        end else begin
          chk("r_beat{id,data,resp,last}", {bus.rid, bus.rdata, bus.rresp, bus.rlast}, exp_r[0]);
          if (bus.rready) void'(exp_r.pop_front());
        end
      end
      if (bus.bvalid) begin
        if (exp_b.size() == 0) begin
          note_fail("b_unexpected_resp");
        end else begin
          chk("b_resp{id,resp}", {bus.bid, bus.bresp}, exp_b[0]);
          if (bus.bready) void'(exp_b.pop_front());
        end
      end
    end
  end

  // entered and left at posedge+1
  task automatic write_burst(input logic [3:0] id, input logic [31:0] addr, input int len,
                             input logic [1:0] burst, input logic [2:0] size,
                             input logic [3:0] strb, input int wlast_at);
    int c;
    model_write(id, addr, len, burst, size, strb, wlast_at);
    bus.awid = id; bus.awaddr = addr; bus.awlen = 8'(len);
    bus.awsize = size; bus.awburst = burst; bus.awvalid = 1'b1; bus.bready = 1'b1;
    c = 0;
    do begin @(negedge clk); c++; end while (!bus.awready && c < 50);
    if (!bus.awready) note_fail("aw_wait");
    @(posedge clk); #1;
    bus.awvalid = 1'b0;
    for (int i = 0; i <= len; i++) begin
      bus.wvalid = 1'b1; bus.wdata = wbuf[i]; bus.wstrb = strb;
      bus.wlast = (i == wlast_at) ? 1'b1 : 1'b0;
      @(negedge clk);
      if (i == 0) begin
        chk("awready_after_aw", bus.awready, 1'b0);
        chk("wready_after_aw", bus.wready, 1'b1);
      end
      c = 0;
      while (!bus.wready && c < 50) begin @(negedge clk); c++; end
      if (!bus.wready) begin note_fail("w_wait"); break; end
      @(posedge clk); #1;
    end
    bus.wvalid = 1'b0; bus.wlast = 1'b0;
    @(negedge clk);
    chk("wready_after_last", bus.wready, 1'b0);
    chk("bvalid_after_last", bus.bvalid, 1'b1);
    last_bresp = bus.bresp;
    @(posedge clk); #1;
    @(negedge clk);
    chk("bvalid_after_b", bus.bvalid, 1'b0);
    chk("awready_after_b", bus.awready, 1'b1);
    bus.bready = 1'b0;
    @(posedge clk); #1;
  endtask

  // entered and left at posedge+1; abort_after>0 pulses rst once that many beats are taken
  task automatic read_burst(input logic [3:0] id, input logic [31:0] addr, input int len,
                            input logic [1:0] burst, input logic [2:0] size,
                            input bit toggle, input int abort_after);
    int c;
    bit done;
    bit aborted;
    model_read(id, addr, len, burst, size);
    ngot = 0; aborted = 1'b0;
    bus.arid = id; bus.araddr = addr; bus.arlen = 8'(len);
    bus.arsize = size; bus.arburst = burst; bus.arvalid = 1'b1;
    c = 0;
    do begin @(negedge clk); c++; end while (!bus.arready && c < 50);
    if (!bus.arready) note_fail("ar_wait");
    @(posedge clk); #1;
    bus.arvalid = 1'b0; bus.rready = 1'b1;
    @(negedge clk);
    chk("rvalid_one_cycle_latency", bus.rvalid, 1'b1);
    done = 1'b0; c = 0;
    while (!done && c < 4 * (len + 1) + 50) begin
      if (bus.rvalid && bus.rready) begin got[ngot] = bus.rdata; ngot++; end
      if (ngot == len + 1) begin
        done = 1'b1;
      end else if (ngot == abort_after) begin
        @(posedge clk); #1;
        bus.rready = 1'b0;
        #2 rst = 1'b0;
        #1;
        chk("abort_rvalid", bus.rvalid, 1'b0);
        chk("abort_rlast", bus.rlast, 1'b0);
        chk("abort_rdata", bus.rdata, 32'h0);
        chk("abort_arready", bus.arready, 1'b0);
        exp_r.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        chk("arready_after_release", bus.arready, 1'b1);
        chk("awready_after_release", bus.awready, 1'b1);
        aborted = 1'b1;
        done = 1'b1;
      end
      if (!done) begin
        @(posedge clk); #1;
        if (toggle) bus.rready = ~bus.rready;
        @(negedge clk);
        c++;
      end
    end
    if (!done) note_fail("r_wait");
    if (!aborted) begin
      @(posedge clk); #1;
      bus.rready = 1'b0;
      @(negedge clk);
      chk("rvalid_after_last", bus.rvalid, 1'b0);
      chk("arready_after_last", bus.arready, 1'b1);
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    bus.awid = 4'h0; bus.awaddr = 32'h0; bus.awlen = 8'd0; bus.awsize = 3'd0;
    bus.awburst = 2'b00; bus.awvalid = 1'b0;
    bus.wdata = 32'h0; bus.wstrb = 4'h0; bus.wlast = 1'b0; bus.wvalid = 1'b0;
    bus.bready = 1'b0;
    bus.arid = 4'h0; bus.araddr = 32'h0; bus.arlen = 8'd0; bus.arsize = 3'd0;
    bus.arburst = 2'b00; bus.arvalid = 1'b0; bus.rready = 1'b0;

    // reset values
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_awready", bus.awready, 1'b0);
    chk("reset_wready", bus.wready, 1'b0);
    chk("reset_arready", bus.arready, 1'b0);
    chk("reset_b{valid,id,resp}", {bus.bvalid, bus.bid, bus.bresp}, 7'h0);
    chk("reset_r{valid,last,id,resp}", {bus.rvalid, bus.rlast, bus.rid, bus.rresp}, 8'h0);
    chk("reset_rdata", bus.rdata, 32'h0);
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    chk("awready_before_first_edge", bus.awready, 1'b0);
    @(posedge clk); #1;
    chk("awready_first_edge", bus.awready, 1'b1);
    chk("arready_first_edge", bus.arready, 1'b1);

    // basic 4-beat write and read-back
    for (int i = 0; i < 4; i++) wbuf[i] = exp4[i];
    write_burst(4'h5, 32'h0, 3, 2'b01, 3'd2, 4'hF, 3);
    chk("t1_bresp", last_bresp, 2'b00);
    chk("model_pin_word1", model_mem[1], 32'hDEADBEEF);
    read_burst(4'h9, 32'h0, 3, 2'b01, 3'd2, 1'b0, -1);
    for (int i = 0; i < 4; i++) chk("t1_readback", got[i], exp4[i]);

    // stalled read: rready toggling
    read_burst(4'h3, 32'h0, 3, 2'b01, 3'd2, 1'b1, -1);
    chk("t2_beats", ngot, 4);
    for (int i = 0; i < 4; i++) chk("t2_stall_readback", got[i], exp4[i]);

    // early wlast: data still written, response SLVERR
    wbuf[0] = 32'h11111111; wbuf[1] = 32'h22222222; wbuf[2] = 32'h33333333; wbuf[3] = 32'h44444444;
    write_burst(4'h2, 32'h40, 3, 2'b01, 3'd2, 4'hF, 1);
    chk("t3_bresp_early_wlast", last_bresp, 2'b10);
    read_burst(4'h1, 32'h40, 3, 2'b01, 3'd2, 1'b0, -1);
    chk("t3_word18", got[2], 32'h33333333);

    // WRAP burst: memory unchanged
    for (int i = 0; i < 4; i++) wbuf[i] = 32'hAAAAAAAA;
    write_burst(4'h6, 32'h0, 3, 2'b10, 3'd2, 4'hF, 3);
    chk("t4_bresp_wrap", last_bresp, 2'b10);
    read_burst(4'h4, 32'h0, 3, 2'b01, 3'd2, 1'b0, -1);
    chk("t4_word0_unchanged", got[0], 32'hFACECAFE);
    chk("t4_word3_unchanged", got[3], 32'h87654321);
    // FIXED read burst: zeros
    read_burst(4'h7, 32'h0, 3, 2'b00, 3'd2, 1'b0, -1);
    chk("t4_fixed_zero0", got[0], 32'h0);
    chk("t4_fixed_zero3", got[3], 32'h0);

    // wrong size single-beat write suppressed
    wbuf[0] = 32'hBBBBBBBB;
    write_burst(4'h8, 32'h0, 0, 2'b01, 3'd1, 4'hF, 0);
    chk("t5_bresp_size", last_bresp, 2'b10);
    read_burst(4'hA, 32'h0, 0, 2'b01, 3'd2, 1'b0, -1);
    chk("t5_word0", got[0], 32'hFACECAFE);

    // byte strobes
    wbuf[0] = 32'hFFFFFFFF;
    write_burst(4'hB, 32'h80, 0, 2'b01, 3'd2, 4'hF, 0);
    chk("t6_bresp_single", last_bresp, 2'b00);
    wbuf[0] = 32'h00000000;
    write_burst(4'hB, 32'h80, 0, 2'b01, 3'd2, 4'b0101, 0);
    read_burst(4'hC, 32'h80, 0, 2'b01, 3'd2, 1'b0, -1);
`ifdef AXI_MEM_WSTRB_EN
    chk("t6_wstrb_merge", got[0], 32'hFF00FF00);
`else
    chk("t6_wstrb_ignored", got[0], 32'h00000000);
`endif

    // reset mid-read, RAM survives
    read_burst(4'hD, 32'h0, 7, 2'b01, 3'd2, 1'b0, 2);
    read_burst(4'hE, 32'h0, 3, 2'b01, 3'd2, 1'b0, -1);
    chk("t7_survive0", got[0], 32'hFACECAFE);
    chk("t7_survive3", got[3], 32'h87654321);

    // index wrap at MEM_DEPTH-2
    for (int i = 0; i < 4; i++) wbuf[i] = 32'hC0DE0000 + 32'(i);
    write_burst(4'h1, 32'h3F8, 3, 2'b01, 3'd2, 4'hF, 3);
    chk("t8_bresp", last_bresp, 2'b00);
    read_burst(4'h2, 32'h0, 1, 2'b01, 3'd2, 1'b0, -1);
    chk("t8_wrap_word0", got[0], 32'hC0DE0002);
    chk("t8_wrap_word1", got[1], 32'hC0DE0003);
    read_burst(4'h3, 32'h3F8, 3, 2'b01, 3'd2, 1'b1, -1);
    chk("t8_wrap_read0", got[0], 32'hC0DE0000);

    // 256-beat burst (len=255), address aliases to word 0
    for (int i = 0; i < 256; i++) wbuf[i] = 32'(i * 3 + 1);
    write_burst(4'hF, 32'h400, 255, 2'b01, 3'd2, 4'hF, 255);
    chk("t9_bresp", last_bresp, 2'b00);
    read_burst(4'h0, 32'h0, 255, 2'b01, 3'd2, 1'b0, -1);
    chk("t9_beats", ngot, 256);
    chk("t9_first", got[0], 32'd1);
    chk("t9_last", got[255], 32'd766);

    chk("r_queue_drained", exp_r.size(), 0);
    chk("b_queue_drained", exp_b.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
